// File: rtl/incline_pkg.sv
// Shared definitions for the incline saturation / averaging path.
// Contents: default widths, FSM state type, clamp-limit helpers.
package incline_pkg;

  localparam int IN_W_D  = 13;
  localparam int OUT_W_D = 10;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Largest positive value of a w-bit two's-complement number.
  function automatic int sat_max(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative value of a w-bit two's-complement number.
  function automatic int sat_min(int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/incline_sat_avg_if.sv
// Sample / result bundle between the inclinometer front-end (master)
// and the saturating averager (slave).
//   incline, incline_vld, flush, clr_sat : master -> slave
//   incline_sat, incline_avg, avg_vld, primed,
//   sat_hi, sat_lo, sat_cnt              : slave -> master
interface incline_sat_avg_if
  import incline_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int CNT_W = 8
);

  logic signed [IN_W-1:0]  incline;
  logic                    incline_vld;
  logic                    flush;
  logic                    clr_sat;
  logic signed [OUT_W-1:0] incline_sat;
  logic signed [OUT_W-1:0] incline_avg;
  logic                    avg_vld;
  logic                    primed;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [CNT_W-1:0]        sat_cnt;

  modport master (
    output incline, incline_vld, flush, clr_sat,
    input  incline_sat, incline_avg, avg_vld, primed, sat_hi, sat_lo, sat_cnt
  );

  modport slave (
    input  incline, incline_vld, flush, clr_sat,
    output incline_sat, incline_avg, avg_vld, primed, sat_hi, sat_lo, sat_cnt
  );

endinterface

// File: rtl/incline_clamp.sv
// Combinational signed clamp from IN_W to OUT_W bits.
//   din    : signed IN_W-bit input
//   dout   : din limited to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   hi_evt : din was above the positive limit
//   lo_evt : din was below the negative limit
module incline_clamp
  import incline_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int OUT_W = OUT_W_D
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    hi_evt,
  output logic                    lo_evt
);

  // Limits expressed at input width so the comparison is a plain signed one.
  localparam logic signed [IN_W-1:0] MAX_I = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] MIN_I = IN_W'(sat_min(OUT_W));

  assign hi_evt = (din > MAX_I);
  assign lo_evt = (din < MIN_I);

  // In range, the upper bits are pure sign extension, so truncation is exact.
  assign dout = hi_evt ? MAX_I[OUT_W-1:0] :
                lo_evt ? MIN_I[OUT_W-1:0] :
                         din[OUT_W-1:0];

endmodule

// File: rtl/incline_sat_avg.sv
// Incline saturator with sticky saturation stats and a 2^LOG_N boxcar average.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of incline_sat_avg_if (sample in, results out)
module incline_sat_avg
  import incline_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int LOG_N = 2,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  incline_sat_avg_if.slave bus
);

  localparam int N     = 1 << LOG_N;
  localparam int SUM_W = OUT_W + LOG_N;
  localparam logic [LOG_N:0]   FILL_LAST = (LOG_N + 1)'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  if (IN_W <= OUT_W) begin : g_bad_width
    $error("incline_sat_avg: IN_W must exceed OUT_W");
  end
  if (LOG_N < 1 || LOG_N > 4) begin : g_bad_depth
    $error("incline_sat_avg: LOG_N must be within 1..4");
  end

  logic signed [OUT_W-1:0] clamp_val;
  logic                    hi_evt, lo_evt;

  incline_clamp #(.IN_W(IN_W), .OUT_W(OUT_W)) u_clamp (
    .din    (bus.incline),
    .dout   (clamp_val),
    .hi_evt (hi_evt),
    .lo_evt (lo_evt)
  );

  state_t                  state_q, state_nxt;
  logic signed [OUT_W-1:0] sat_q;
  logic signed [OUT_W-1:0] win_q [N];
  logic signed [SUM_W-1:0] sum_q;
  logic [LOG_N-1:0]        wr_ptr_q;
  logic [LOG_N:0]          fill_cnt_q;
  logic                    avg_vld_q, avg_vld_nxt;
  logic                    sat_hi_q, sat_lo_q;
  logic [CNT_W-1:0]        sat_cnt_q, cnt_base;

  // flush discards a coincident sample completely, stats included.
  logic take, evt;
  assign take = bus.incline_vld && !bus.flush;
  assign evt  = take && (hi_evt || lo_evt);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state_q;
    avg_vld_nxt = 1'b0;
    if (bus.flush) begin
      state_nxt = FILL;
    end else if (bus.incline_vld) begin
      case (state_q)
        FILL: if (fill_cnt_q == FILL_LAST) begin
          state_nxt   = RUN;
          avg_vld_nxt = 1'b1;
        end
        RUN:  avg_vld_nxt = 1'b1;
        default: state_nxt = FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      avg_vld_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      avg_vld_q <= avg_vld_nxt;
    end
  end

  // NOTE: the window is only N words and must read as zero after reset for
  // the running sum to stay consistent, so it is reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) win_q[i] <= '0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < N; i++) win_q[i] <= '0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
    end else if (bus.incline_vld) begin
      win_q[wr_ptr_q] <= clamp_val;
      // Add the newest sample, drop the one it overwrites; SUM_W bits hold
      // N full-scale samples, so this cannot wrap.
      sum_q <= sum_q
             + {{LOG_N{clamp_val[OUT_W-1]}}, clamp_val}
             - {{LOG_N{win_q[wr_ptr_q][OUT_W-1]}}, win_q[wr_ptr_q]};
      wr_ptr_q <= wr_ptr_q + LOG_N'(1);
      if (state_q == FILL) fill_cnt_q <= fill_cnt_q + (LOG_N + 1)'(1);
    end
  end

  // clr_sat clears first, then a coincident event is recorded on top of it.
  assign cnt_base = bus.clr_sat ? '0 : sat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q     <= '0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      if (take) sat_q <= clamp_val;
      sat_hi_q  <= (sat_hi_q && !bus.clr_sat) || (evt && hi_evt);
      sat_lo_q  <= (sat_lo_q && !bus.clr_sat) || (evt && lo_evt);
      sat_cnt_q <= (evt && cnt_base != CNT_MAX) ? cnt_base + CNT_W'(1) : cnt_base;
    end
  end

  assign bus.incline_sat = sat_q;
  assign bus.incline_avg = OUT_W'(sum_q >>> LOG_N);   // floors toward -inf
  assign bus.avg_vld     = avg_vld_q;
  assign bus.primed      = (state_q == RUN);
  assign bus.sat_hi      = sat_hi_q;
  assign bus.sat_lo      = sat_lo_q;
  assign bus.sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_incline_sat_avg.sv
// Self-checking bench for incline_sat_avg at default parameters (N = 4).
module tb_incline_sat_avg;
  import incline_pkg::*;

  localparam int IN_W  = 13;
  localparam int OUT_W = 10;
  localparam int LOG_N = 2;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  incline_sat_avg_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  incline_sat_avg #(.IN_W(IN_W), .OUT_W(OUT_W), .LOG_N(LOG_N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  typedef struct {
    int incline;
    bit vld, flush, clr;
    int e_sat;
    bit e_av, e_pr, e_hi, e_lo;
    int e_cnt, e_avg;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input bit vld, input bit fl, input bit clr);
    @(negedge clk);
    bus.incline     = IN_W'(v);
    bus.incline_vld = vld;
    bus.flush       = fl;
    bus.clr_sat     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input bit hi, input bit lo, input int cnt);
    check({tag, "_hi"}, int'(bus.sat_hi), int'(hi));
    check({tag, "_lo"}, int'(bus.sat_lo), int'(lo));
    check({tag, "_cnt"}, int'(bus.sat_cnt), cnt);
  endtask

  // Scoreboard: every avg_vld pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && bus.avg_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected_avg_vld: got avg %0d expected no pulse", bus.incline_avg);
        end else begin
          check("sb_avg", int'(bus.incline_avg), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    //           incline vld fl clr  sat  av pr hi lo cnt  avg
    vecs[0]  = '{  165,  1, 0, 0,  165, 0, 0, 0, 0, 0,   41};
    vecs[1]  = '{  165,  1, 0, 0,  165, 0, 0, 0, 0, 0,   82};
    vecs[2]  = '{  165,  1, 0, 0,  165, 0, 0, 0, 0, 0,  123};
    vecs[3]  = '{  165,  1, 0, 0,  165, 1, 1, 0, 0, 0,  165};
    vecs[4]  = '{-1339,  1, 0, 0, -512, 1, 1, 0, 1, 1,   -5};
    vecs[5]  = '{ -215,  1, 0, 0, -215, 1, 1, 0, 1, 1, -100};
    vecs[6]  = '{ 1316,  1, 0, 0,  511, 1, 1, 1, 1, 2,  -13};
    vecs[7]  = '{  511,  1, 0, 0,  511, 1, 1, 1, 1, 2,   73};
    vecs[8]  = '{  511,  1, 0, 0,  511, 1, 1, 1, 1, 2,  329};
    vecs[9]  = '{ -512,  1, 0, 0, -512, 1, 1, 1, 1, 2,  255};
    vecs[10] = '{ -512,  1, 0, 0, -512, 1, 1, 1, 1, 2,   -1};
    vecs[11] = '{ -513,  1, 0, 0, -512, 1, 1, 1, 1, 3, -257};
    vecs[12] = '{  999,  0, 0, 0, -512, 0, 1, 1, 1, 3, -257};
    vecs[13] = '{  512,  1, 0, 0,  511, 1, 1, 1, 1, 4, -257};
    vecs[14] = '{ 4000,  1, 1, 0,  511, 0, 0, 1, 1, 4,    0};
    vecs[15] = '{  100,  1, 0, 0,  100, 0, 0, 1, 1, 4,   25};
    vecs[16] = '{  100,  1, 0, 0,  100, 0, 0, 1, 1, 4,   50};
    vecs[17] = '{  100,  1, 0, 0,  100, 0, 0, 1, 1, 4,   75};
    vecs[18] = '{  100,  1, 0, 0,  100, 1, 1, 1, 1, 4,  100};
    vecs[19] = '{  100,  1, 0, 1,  100, 1, 1, 0, 0, 0,  100};

    bus.incline     = '0;
    bus.incline_vld = 1'b0;
    bus.flush       = 1'b0;
    bus.clr_sat     = 1'b0;
    rst_n           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sat", int'(bus.incline_sat), 0);
    check("rst_avg", int'(bus.incline_avg), 0);
    check("rst_avg_vld", int'(bus.avg_vld), 0);
    check("rst_primed", int'(bus.primed), 0);
    check_stats("rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      if (vecs[i].e_av) exp_q.push_back(vecs[i].e_avg);
      drive(vecs[i].incline, vecs[i].vld, vecs[i].flush, vecs[i].clr);
      check({t, "_sat"}, int'(bus.incline_sat), vecs[i].e_sat);
      check({t, "_avg_vld"}, int'(bus.avg_vld), int'(vecs[i].e_av));
      check({t, "_primed"}, int'(bus.primed), int'(vecs[i].e_pr));
      check({t, "_avg"}, int'(bus.incline_avg), vecs[i].e_avg);
      check_stats(t, vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_cnt);
    end

    // Counter saturation: 300 saturating samples into a window of 100s.
    for (int i = 0; i < 300; i++) begin
      case (i)
        0:       exp_q.push_back(202);
        1:       exp_q.push_back(305);
        2:       exp_q.push_back(408);
        default: exp_q.push_back(511);
      endcase
      drive(4000, 1, 0, 0);
    end
    check("cnt_hold_sat", int'(bus.incline_sat), 511);
    check_stats("cnt_hold", 1, 0, 255);

    // clr_sat with a saturating sample records exactly one event.
    exp_q.push_back(511);
    drive(4000, 1, 0, 1);
    check_stats("clr_hi", 1, 0, 1);
    exp_q.push_back(255);
    drive(-4000, 1, 0, 1);
    check("clr_lo_sat", int'(bus.incline_sat), -512);
    check_stats("clr_lo", 0, 1, 1);

    // clr_sat and flush together, no sample.
    drive(0, 0, 1, 1);
    check("clrfl_primed", int'(bus.primed), 0);
    check("clrfl_avg", int'(bus.incline_avg), 0);
    check("clrfl_sat", int'(bus.incline_sat), -512);
    check_stats("clrfl", 0, 0, 0);

    // Reset mid-window, asserted between clock edges.
    drive(600, 1, 0, 0);
    check("mid_avg1", int'(bus.incline_avg), 127);
    drive(600, 1, 0, 0);
    check("mid_avg2", int'(bus.incline_avg), 255);
    check_stats("mid", 1, 0, 2);
    bus.incline_vld = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sat", int'(bus.incline_sat), 0);
    check("arst_avg", int'(bus.incline_avg), 0);
    check("arst_primed", int'(bus.primed), 0);
    check("arst_avg_vld", int'(bus.avg_vld), 0);
    check_stats("arst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) exp_q.push_back(8);
      drive(8, 1, 0, 0);
      check($sformatf("refill%0d_avg_vld", i), int'(bus.avg_vld), int'(i == 4));
      check($sformatf("refill%0d_avg", i), int'(bus.incline_avg), 2 * i);
    end
    drive(0, 0, 0, 0);
    check("idle_avg_vld", int'(bus.avg_vld), 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/incline_sat_avg.md
Name: incline_sat_avg

Overview:
Parametrised successor to the fixed 13→10-bit incline saturator. It clamps each valid signed incline sample to OUT_W bits and keeps sticky high/low saturation flags plus a saturation event counter. It also produces a boxcar average over the last 2^LOG_N saturated samples. It sits between the inclinometer front-end and the assist/torque computation.

Parameters:
IN_W, 13, signed input width; IN_W > OUT_W is required (elaboration-time assertion).
OUT_W, 10, signed output width; clamp range is [-2^(OUT_W-1), 2^(OUT_W-1)-1].
LOG_N, 2, log2 of the averaging window depth N; allowed range 1..4.
CNT_W, 8, width of the saturation event counter.

Ports:
clk  in  1  system clock, all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
incline  in  IN_W  signed raw incline sample.
incline_vld  in  1  one-cycle qualifier for incline.
flush  in  1  synchronous clear of the window, running sum and fill state.
clr_sat  in  1  synchronous clear of sat_hi, sat_lo and sat_cnt.
incline_sat  out  OUT_W  signed; registered clamp of the last valid sample.
incline_avg  out  OUT_W  signed; sum >>> LOG_N.
avg_vld  out  1  one-cycle pulse; incline_avg is valid for a new sample.
primed  out  1  high once N samples have been taken since reset or flush.
sat_hi  out  1  sticky; a sample exceeded the positive limit.
sat_lo  out  1  sticky; a sample was below the negative limit.
sat_cnt  out  CNT_W  count of saturating samples; holds at 2^CNT_W-1.

Behaviour:
- Reset (async, rst_n=0):
  - incline_sat=0, sum=0, all buffer entries=0, wr_ptr=0, fill_cnt=0.
  - State=FILL; primed, avg_vld, sat_hi, sat_lo = 0; sat_cnt=0.
- Clamp (combinational):
  - incline > 2^(OUT_W-1)-1 → max, hi_evt=1.
  - incline < -2^(OUT_W-1) → min, lo_evt=1.
  - Otherwise the low OUT_W bits pass through unchanged.
- Latency: incline_vld at edge T → incline_sat, buffer entry, sum, flags and sat_cnt all updated at T+1.
  - avg_vld is high for the single cycle after T+1, only if that sample leaves primed=1.
  - incline_avg is combinational from the registered sum.
- Window: circular buffer of N entries of OUT_W bits; wr_ptr wraps N-1→0.
  - Running sum is signed, OUT_W+LOG_N bits: sum ← sum + new − buf[wr_ptr]. This never overflows.
  - incline_avg uses an arithmetic right shift, so it floors toward −∞.
- FSM, state FILL (primed=0):
  - Each valid sample increments fill_cnt.
  - The sample that brings fill_cnt to N moves the FSM to RUN and raises avg_vld.
  - No avg_vld is produced for the first N−1 samples.
- FSM, state RUN (primed=1): every valid sample produces avg_vld.
- No incline_vld: all state holds and avg_vld=0.
- flush:
  - Zeroes the buffer, sum, wr_ptr and fill_cnt; state→FILL; primed=0.
  - incline_sat, flags and sat_cnt are unaffected.
  - flush together with incline_vld: flush wins and the sample is discarded entirely, including flags and counter.
- Saturation stats:
  - hi_evt sets sat_hi; lo_evt sets sat_lo.
  - Any event increments sat_cnt, which holds at all-ones.
  - clr_sat together with a saturating sample: the result is one event only (flag=1, sat_cnt=1).
  - clr_sat and flush are independent and may be asserted together.
- Reset asserted mid-window: immediate return to reset values; no stale avg_vld after release.

Decomposition:
- Package incline_pkg:
  - Default widths IN_W_D=13, OUT_W_D=10.
  - state_t enum {FILL, RUN}.
  - Functions sat_max(OUT_W) and sat_min(OUT_W).
- One sub-module, incline_clamp:
  - Purely combinational parametrised clamp.
  - Outputs: clamped value, hi_evt, lo_evt.
  - Reusable by other saturating paths.
- The top level holds the FSM, the buffer, the running sum and the stats.

Test Plan (defaults, N=4):
- Reset, then 4× incline=165 → avg_vld only after the 4th sample, incline_avg=165, primed=1, sat flags 0.
- incline=13'b1101011000101 (−1339) → incline_sat=10'h200 (−512), sat_lo=1, sat_cnt=1; then −215 → incline_sat=10'b1100101001, sat_lo stays 1.
- incline=1316 → incline_sat=10'h1FF (511), sat_hi=1. Primed window fed 511, 511, −512, −512 → sum −2, incline_avg=−1 (floor).
- 300 consecutive samples of 4000 → sat_cnt=255 held. clr_sat together with one more 4000 sample → sat_cnt=1, sat_hi=1, sat_lo=0.
- In RUN, pulse flush together with incline_vld → no avg_vld, primed=0, sum=0. The next 3 samples give no avg_vld; the 4th gives avg_vld.
- Drop rst_n after 2 samples in FILL → all outputs zero immediately. After release, 4 samples are needed before avg_vld.
